// File: rtl/fb_pkg.sv
// Shared definitions for the 1-bit 320x240 frame buffer read path:
// geometry defaults, scan FSM states and the per-pixel tag layouts.
package fb_pkg;

  localparam int IM_WIDTH   = 320;
  localparam int IM_HEIGHT  = 240;
  localparam int ADDR_WIDTH = 17;
  localparam int FB_PIXELS  = IM_WIDTH * IM_HEIGHT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fb_state_e;

  // Travels next to each BRAM read while the data is in flight.
  typedef struct packed {
    logic issued;
    logic sof;
    logic eol;
    logic eof;
  } fb_tag_t;

  // One landed pixel: BRAM data plus its raster markers.
  typedef struct packed {
    logic data;
    logic sof;
    logic eol;
    logic eof;
  } fb_pix_t;

  // Width of a counter that must hold values 0..max_value.
  function automatic int fb_count_width(input int max_value);
    return (max_value > 0) ? $clog2(max_value + 1) : 1;
  endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// Small synchronous landing FIFO for pixels returning from the BRAM.
// Head is visible combinationally; count reports the occupancy so the
// issuer can reserve space before a read is launched.
module fb_skid_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head,
  output logic [fb_count_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = fb_count_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_pop = pop && (count_reg != '0);

  // Storage write; entries are only observed once counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  // The issuer reserves a slot for every read, so a push into a full
  // FIFO without a matching pop means the reservation logic is broken.
  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(push && !do_pop && (count_reg == CNT_FULL))
  );

endmodule

// File: rtl/fb_scan_reader.sv
// Raster-order read engine for the 1-bit frame buffer. Issues one BRAM
// read per cycle while landing space is reserved, tracks each read with a
// tag pipeline matching the BRAM latency and presents a valid/ready pixel
// stream with start-of-frame, end-of-line and end-of-frame markers.
module fb_scan_reader #(
  parameter int IM_WIDTH   = fb_pkg::IM_WIDTH,
  parameter int IM_HEIGHT  = fb_pkg::IM_HEIGHT,
  parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic                  bram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof
);

  import fb_pkg::*;

  // Landing space covers every read in flight plus two extra slots, which
  // is what lets the issuer sustain one read per clock with ready high.
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = fb_count_width(FIFO_DEPTH);
  localparam int XW         = (IM_WIDTH > 1) ? $clog2(IM_WIDTH) : 1;
  localparam int YW         = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1;
  localparam logic [XW-1:0]  X_LAST      = XW'(IM_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST      = YW'(IM_HEIGHT - 1);
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_rd_latency
    $error("fb_scan_reader: RD_LATENCY must be 1 or 2");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(IM_WIDTH * IM_HEIGHT)) begin : g_bad_addr_width
    $error("fb_scan_reader: ADDR_WIDTH too small for the frame");
  end

  fb_state_e state_reg;
  fb_state_e state_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;

  logic                     issue;
  logic                     room;
  logic                     last_pix;
  logic                     push;
  logic                     pop;
  fb_tag_t                  issue_tag;
  fb_tag_t                  emerge_tag;
  fb_tag_t [RD_LATENCY-1:0] tag_pipe;
  logic [CNT_W-1:0]         in_flight;
  logic [CNT_W-1:0]         fifo_count;
  fb_pix_t                  push_pix;
  fb_pix_t                  head_pix;

  assign last_pix = (x_reg == X_LAST) && (y_reg == Y_LAST);

  // Reserve a landing slot for every outstanding read before issuing.
  assign room = ({1'b0, in_flight} + {1'b0, fifo_count}) < DEPTH_LIMIT;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and issue decision.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (room) begin
          issue = 1'b1;
          if (last_pix) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The eof pixel is the last one out, so its handshake means the
        // tag pipeline and FIFO are both empty from the next edge on.
        if (pop && head_pix.eof) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Raster counters kept separately from the linear address (no multiply).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (state_reg == IDLE && start) begin
      addr_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (issue) begin
      addr_reg <= addr_reg + ADDR_WIDTH'(1);
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

  // Markers for the address being issued this cycle.
  always_comb begin
    issue_tag        = '0;
    issue_tag.issued = issue;
    issue_tag.sof    = issue && (x_reg == '0) && (y_reg == '0);
    issue_tag.eol    = issue && (x_reg == X_LAST);
    issue_tag.eof    = issue && last_pix;
  end

  // Tag shift register aligned with the BRAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Number of reads launched whose data has not yet landed.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(tag_pipe[i].issued);
    end
  end

  // Only cycles that actually issued a read deliver data to the FIFO.
  assign emerge_tag = tag_pipe[RD_LATENCY-1];
  assign push       = emerge_tag.issued;
  assign push_pix   = {bram_dout, emerge_tag.sof, emerge_tag.eol, emerge_tag.eof};

  fb_skid_fifo #(
    .WIDTH ($bits(fb_pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_pix),
    .pop       (pop),
    .head      (head_pix),
    .count     (fifo_count)
  );

  // Stream side: the FIFO head, forced to zero whenever nothing is valid.
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid && head_pix.data;
  assign out_sof   = out_valid && head_pix.sof;
  assign out_eol   = out_valid && head_pix.eol;
  assign out_eof   = out_valid && head_pix.eof;

  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);
  assign bram_addr  = addr_reg;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: two instances (read latency 1 and 2) on a
// reduced 16x6 frame share stimulus; each has its own pattern BRAM model
// and its own stream scoreboard.
`timescale 1ns/1ps
module tb_fb_scan_reader;

  localparam int W    = 16;
  localparam int H    = 6;
  localparam int AW   = 7;
  localparam int NPIX = W * H;

  typedef struct {
    int         idx;
    logic [3:0] word;   // {data, sof, eol, eof}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic out_ready;

  logic [1:0]         busy;
  logic [1:0]         frame_done;
  logic [1:0][AW-1:0] bram_addr;
  logic [1:0]         bram_dout;
  logic [1:0]         out_valid;
  logic [1:0]         out_data;
  logic [1:0]         out_sof;
  logic [1:0]         out_eol;
  logic [1:0]         out_eof;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  int pix_cnt [2];
  int done_cnt [2];
  int sof_cnt [2];
  int eol_cnt [2];
  int eof_cnt [2];
  int first_valid [2];
  int first_hs [2];
  int last_hs [2];
  int eof_cyc [2];
  logic [3:0] cap [2][NPIX];
  logic       hold_prev [2];
  logic [3:0] prev_word [2];
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pat(input logic [AW-1:0] a);
    return a[0] ^ a[4];
  endfunction

  function automatic logic [3:0] exp_word(input int idx);
    logic [AW-1:0] a;
    a = AW'(idx);
    return {pat(a), idx == 0, (idx % W) == (W - 1), idx == (NPIX - 1)};
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [1:0] rd_pipe;

    fb_scan_reader #(
      .IM_WIDTH   (W),
      .IM_HEIGHT  (H),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (gi + 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy[gi]),
      .frame_done (frame_done[gi]),
      .bram_addr  (bram_addr[gi]),
      .bram_dout  (bram_dout[gi]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready),
      .out_data   (out_data[gi]),
      .out_sof    (out_sof[gi]),
      .out_eol    (out_eol[gi]),
      .out_eof    (out_eof[gi])
    );

    // Pattern BRAM with gi+1 cycles of read latency.
    always @(posedge clk) begin
      rd_pipe[0] <= pat(bram_addr[gi]);
      rd_pipe[1] <= rd_pipe[0];
    end
    assign bram_dout[gi] = rd_pipe[gi];
  end

  // Stream scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [3:0] word;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        word = {out_data[d], out_sof[d], out_eol[d], out_eof[d]};
        if (hold_prev[d]) begin
          chk("hold_valid", d, 32'(out_valid[d]), 32'd1);
          chk("hold_stable", d, 32'(word), 32'(prev_word[d]));
        end
        if (out_valid[d] && first_valid[d] < 0) first_valid[d] = cyc;
        if (out_valid[d] && out_ready) begin
          if (pix_cnt[d] >= NPIX) begin
            chk("pix_overrun", d, 32'(pix_cnt[d]), 32'(NPIX - 1));
          end else begin
            chk("pixel", d, 32'(word), 32'(exp_word(pix_cnt[d])));
            cap[d][pix_cnt[d]] = word;
          end
          if (first_hs[d] < 0) first_hs[d] = cyc;
          last_hs[d] = cyc;
          sof_cnt[d] += int'(out_sof[d]);
          eol_cnt[d] += int'(out_eol[d]);
          eof_cnt[d] += int'(out_eof[d]);
          if (out_eof[d]) eof_cyc[d] = cyc;
          pix_cnt[d]++;
        end
        hold_prev[d] = out_valid[d] && !out_ready;
        prev_word[d] = word;
        if (frame_done[d]) begin
          done_cnt[d]++;
          chk("done_after_eof", d, 32'(cyc), 32'(eof_cyc[d] + 1));
        end
      end
    end
  end

  task automatic reset_mon();
    for (int d = 0; d < 2; d++) begin
      pix_cnt[d] = 0; done_cnt[d] = 0; sof_cnt[d] = 0; eol_cnt[d] = 0; eof_cnt[d] = 0;
      first_valid[d] = -1; first_hs[d] = -1; last_hs[d] = -1; eof_cyc[d] = -10;
      hold_prev[d] = 1'b0;
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_busy"}, d, 32'(busy[d]), 32'd0);
      chk({tag, "_frame_done"}, d, 32'(frame_done[d]), 32'd0);
      chk({tag, "_valid"}, d, 32'(out_valid[d]), 32'd0);
      chk({tag, "_data"}, d, 32'(out_data[d]), 32'd0);
      chk({tag, "_markers"}, d, 32'({out_sof[d], out_eol[d], out_eof[d]}), 32'd0);
      chk({tag, "_addr"}, d, 32'(bram_addr[d]), 32'd0);
    end
  endtask

  // One full frame: mode 0 = ready high, 1 = random ready.
  task automatic run_frame(input int mode, input int stall_at, input int stall_len, input bit extra_starts);
    int budget;
    int stall_left;
    int start_cyc;
    bit stalled;
    reset_mon();
    mon_en = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    stalled = 1'b0;
    stall_left = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && budget < 3000) begin
      if (!stalled && stall_len > 0 && pix_cnt[0] >= stall_at) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == stall_len / 2 || stall_left == 1) begin
          for (int d = 0; d < 2; d++)
            chk("stall_addr", d, 32'(bram_addr[d]), 32'(pix_cnt[d] + d + 3));
        end
        stall_left--;
      end else begin
        out_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = extra_starts && (pix_cnt[0] == 10 || frame_done[0]);
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("frame_finished", 0, 32'(budget < 3000), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("pixel_count", d, 32'(pix_cnt[d]), 32'(NPIX));
      chk("done_count", d, 32'(done_cnt[d]), 32'd1);
      chk("sof_count", d, 32'(sof_cnt[d]), 32'd1);
      chk("eol_count", d, 32'(eol_cnt[d]), 32'(H));
      chk("eof_count", d, 32'(eof_cnt[d]), 32'd1);
      chk("idle_after", d, 32'(busy[d]), 32'd0);
      chk("first_valid_latency", d, 32'(first_valid[d] - start_cyc), 32'(d + 2));
      if (mode == 0)
        chk("throughput", d, 32'(last_hs[d] - first_hs[d]), 32'(NPIX - 1));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   waited;
    tbl[0] = '{idx: 0,  word: 4'b0100};
    tbl[1] = '{idx: 15, word: 4'b1010};
    tbl[2] = '{idx: 16, word: 4'b1000};
    tbl[3] = '{idx: 17, word: 4'b0000};
    tbl[4] = '{idx: 31, word: 4'b0010};
    tbl[5] = '{idx: 47, word: 4'b1010};
    tbl[6] = '{idx: 50, word: 4'b1000};
    tbl[7] = '{idx: 95, word: 4'b0011};

    reset_mon();
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ready high, extra start pulses mid-frame and during DONE.
    run_frame(0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++)
      for (int d = 0; d < 2; d++)
        chk($sformatf("table_px%0d", tbl[i].idx), d, 32'(cap[d][tbl[i].idx]), 32'(tbl[i].word));

    // Random backpressure with a long stall part-way through.
    run_frame(1, 40, 60, 1'b0);

    // Reset in the middle of a frame.
    reset_mon();
    mon_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (pix_cnt[0] < 40 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reach_mid_frame", 0, 32'(waited < 1000), 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle("midreset");
    rst_n = 1'b1;
    reset_mon();
    mon_en = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("no_done_after_reset", d, 32'(done_cnt[d]), 32'd0);
      chk("no_output_after_reset", d, 32'(pix_cnt[d]), 32'd0);
      chk("idle_after_reset", d, 32'(busy[d]), 32'd0);
    end

    // Fresh frame after the abort must start again from address 0.
    run_frame(0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
